// File: rtl/pad_sweep_sequencer.sv
// pad_sweep_sequencer
//   Exhaustive stimulus/check stage for NPADS pads sharing one tri-state net.
//   On start it steps vec = {ie, oe, to_pad} from 0 to all-ones, drives the
//   pad controls, waits SETTLE_CYCLES, then compares from_pad against the
//   wired-OR resolution of all enabled drivers gated by each pad's ie.
//
//   Optional build macro: PAD_SWEEP_STOP_ON_ERROR_EN
//     defined   : first mismatch ends the sweep; the failing vector stays
//                 driven on the pad controls while in DONE.
//     undefined : every vector is checked; err_count holds the total.
//
// Ports
//   clk             sole clock, all state changes on posedge
//   rst             synchronous active-high reset
//   start           begin sweep, sampled only in IDLE or DONE
//   ie/oe/to_pad    per-pad input enable, output enable, drive value
//   from_pad        per-pad receive value
//   busy            high in APPLY/SETTLE/CHECK
//   done            high in DONE
//   error           sticky mismatch flag since last start
//   err_count       mismatching vectors, saturating at 255
//   first_fail_vec  {ie,oe,to_pad} of the first failing vector
//   first_fail_mask pads that mismatched on the first failing vector
module pad_sweep_sequencer #(
    parameter int NPADS         = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [NPADS-1:0]       ie,
    output logic [NPADS-1:0]       oe,
    output logic [NPADS-1:0]       to_pad,
    input  logic [NPADS-1:0]       from_pad,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [7:0]             err_count,
    output logic [3*NPADS-1:0]     first_fail_vec,
    output logic [NPADS-1:0]       first_fail_mask
);

    localparam int VW = 3 * NPADS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [VW-1:0]    vec_q;
    logic [3:0]       cnt_q;

    logic [NPADS-1:0] vec_ie, vec_oe, vec_tp;
    logic [NPADS-1:0] exp_pad, mm;
    logic             any_drive, mismatch, vec_last, drive_en;

    assign {vec_ie, vec_oe, vec_tp} = vec_q;

    // Reference resolution: the net is 1 when any pad drives 1, else it
    // floats and resolves to 0; a pad only sees it when its ie is set.
    always_comb begin
        any_drive = |(vec_oe & vec_tp);
        exp_pad   = vec_ie & {NPADS{any_drive}};
        mm        = from_pad ^ exp_pad;
        mismatch  = (state_q == CHECK) && (mm != '0);
        vec_last  = &vec_q;
    end

    // NOTE: every signal assigned in this block gets a default first so that
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = APPLY;
            APPLY:      state_d = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
            SETTLE:     if (cnt_q <= 4'd1) state_d = CHECK;
`ifdef PAD_SWEEP_STOP_ON_ERROR_EN
            CHECK:      state_d = (mismatch || vec_last) ? DONE : APPLY;
`else
            CHECK:      state_d = vec_last ? DONE : APPLY;
`endif
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
        done = (state_q == DONE);
`ifdef PAD_SWEEP_STOP_ON_ERROR_EN
        // The vector that stopped the sweep stays on the pads for inspection.
        drive_en = busy || done;
`else
        drive_en = busy;
`endif
        ie     = drive_en ? vec_ie : '0;
        oe     = drive_en ? vec_oe : '0;
        to_pad = drive_en ? vec_tp : '0;
    end

    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q           <= '0;
            cnt_q           <= '0;
            error           <= 1'b0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        vec_q           <= '0;
                        error           <= 1'b0;
                        err_count       <= '0;
                        first_fail_vec  <= '0;
                        first_fail_mask <= '0;
                    end
                end
                APPLY:  cnt_q <= 4'(SETTLE_CYCLES);
                SETTLE: cnt_q <= cnt_q - 4'd1;
                CHECK: begin
                    if (mismatch) begin
                        error <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        // Only the first failure since start is captured.
                        if (!error) begin
                            first_fail_vec  <= vec_q;
                            first_fail_mask <= mm;
                        end
                    end
`ifdef PAD_SWEEP_STOP_ON_ERROR_EN
                    if (!mismatch && !vec_last) vec_q <= vec_q + 1'b1;
`else
                    // All-ones is the final vector; never wrap back to 0.
                    if (!vec_last) vec_q <= vec_q + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pad_sweep_sequencer.sv
// Self-checking bench for pad_sweep_sequencer. Two instances (NPADS=2/SETTLE=1
// and NPADS=1/SETTLE=0) sit on behavioural shared nets with injectable
// stuck-at-0/stuck-at-1 faults per pad; a sweep-level reference model walks
// every vector with plain arithmetic to predict results and latency.
module tb_pad_sweep_sequencer;

    localparam int NA = 2, SA = 1;
    localparam int NB = 1, SB = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;

    logic [NA-1:0]   ie_a, oe_a, tp_a, fp_a, ffm_a;
    logic [3*NA-1:0] ffv_a;
    logic            busy_a, done_a, error_a;
    logic [7:0]      ec_a;

    logic [NB-1:0]   ie_b, oe_b, tp_b, fp_b, ffm_b;
    logic [3*NB-1:0] ffv_b;
    logic            busy_b, done_b, error_b;
    logic [7:0]      ec_b;

    logic [3:0] s0_a = '0, s1_a = '0, s0_b = '0, s1_b = '0;

    int errors = 0;
    int checks = 0;

    pad_sweep_sequencer #(.NPADS(NA), .SETTLE_CYCLES(SA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .ie(ie_a), .oe(oe_a), .to_pad(tp_a), .from_pad(fp_a),
        .busy(busy_a), .done(done_a), .error(error_a), .err_count(ec_a),
        .first_fail_vec(ffv_a), .first_fail_mask(ffm_a)
    );

    pad_sweep_sequencer #(.NPADS(NB), .SETTLE_CYCLES(SB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .ie(ie_b), .oe(oe_b), .to_pad(tp_b), .from_pad(fp_b),
        .busy(busy_b), .done(done_b), .error(error_b), .err_count(ec_b),
        .first_fail_vec(ffv_b), .first_fail_mask(ffm_b)
    );

    // Shared-net behaviour: any enabled driver of 1 pulls the net high, an
    // undriven net reads 0, a pad only receives when its ie is set; then
    // per-pad stuck-at faults override the received value.
    function automatic logic [3:0] resolve(input int n, input logic [3:0] pie,
                                           input logic [3:0] poe, input logic [3:0] ptp,
                                           input logic [3:0] s0, input logic [3:0] s1);
        logic       net;
        logic [3:0] r;
        net = 1'b0;
        r   = '0;
        for (int j = 0; j < n; j++) if (poe[j] && ptp[j]) net = 1'b1;
        for (int i = 0; i < n; i++) r[i] = ((pie[i] && net) && !s0[i]) || s1[i];
        return r;
    endfunction

    logic [3:0] ra, rb;
    always_comb begin
        ra   = resolve(NA, 4'(ie_a), 4'(oe_a), 4'(tp_a), s0_a, s1_a);
        rb   = resolve(NB, 4'(ie_b), 4'(oe_b), 4'(tp_b), s0_b, s1_b);
        fp_a = ra[NA-1:0];
        fp_b = rb[NB-1:0];
    end

    // Selected-instance view so one sweep task serves both instances.
    int         sel = 0;
    logic       done_s, busy_s, error_s;
    logic [7:0] ec_s;
    logic [11:0] ffv_s;
    logic [3:0] ffm_s, ie_s, oe_s, tp_s;
    always_comb begin
        if (sel == 0) begin
            done_s = done_a; busy_s = busy_a; error_s = error_a; ec_s = ec_a;
            ffv_s = 12'(ffv_a); ffm_s = 4'(ffm_a);
            ie_s = 4'(ie_a); oe_s = 4'(oe_a); tp_s = 4'(tp_a);
        end else begin
            done_s = done_b; busy_s = busy_b; error_s = error_b; ec_s = ec_b;
            ffv_s = 12'(ffv_b); ffm_s = 4'(ffm_b);
            ie_s = 4'(ie_b); oe_s = 4'(oe_b); tp_s = 4'(tp_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Sweep-level reference: walk all vectors, count those where any pad's
    // received value differs from ie[i] & (some pad drives 1).
    task automatic model(input int n, input logic [3:0] s0, input logic [3:0] s1,
                         output int errs, output int first,
                         output logic [11:0] fvec, output logic [3:0] fmask);
        int         nv, m;
        logic [3:0] vie, voe, vtp, got, mmv;
        logic       net;
        nv = 1 << (3 * n);
        m  = (1 << n) - 1;
        errs = 0; first = -1; fvec = '0; fmask = '0;
        for (int v = 0; v < nv; v++) begin
            vie = 4'((v >> (2 * n)) & m);
            voe = 4'((v >> n) & m);
            vtp = 4'(v & m);
            net = ((voe & vtp) != 4'd0);
            got = resolve(n, vie, voe, vtp, s0, s1);
            mmv = '0;
            for (int i = 0; i < n; i++) mmv[i] = got[i] ^ (vie[i] && net);
            if (mmv != 4'd0) begin
                if (errs < 255) errs++;
                if (first < 0) begin
                    first = v; fvec = 12'(v); fmask = mmv;
                end
            end
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) start_a = v;
        else            start_b = v;
    endtask

    // One full sweep on instance 'which' with the given faults; optionally
    // pulses start once while busy, which must be ignored.
    task automatic sweep(input string tag, input int which, input logic [3:0] s0,
                         input logic [3:0] s1, input bit inject);
        int n, s, errs, first, full, exp_cycles, cycles, inject_at;
        logic [11:0] fvec;
        logic [3:0]  fmask, mask;
        bit          busy_ok;
        logic [7:0]  ec_hold;
        n    = (which == 0) ? NA : NB;
        s    = (which == 0) ? SA : SB;
        mask = 4'((1 << n) - 1);
        sel  = which;
        if (which == 0) begin s0_a = s0 & mask; s1_a = s1 & mask; end
        else            begin s0_b = s0 & mask; s1_b = s1 & mask; end
        model(n, s0 & mask, s1 & mask, errs, first, fvec, fmask);
        full       = (s + 2) << (3 * n);
        exp_cycles = full;
`ifdef PAD_SWEEP_STOP_ON_ERROR_EN
        if (first >= 0) begin
            exp_cycles = (first + 1) * (s + 2);
            errs       = 1;
        end
`endif
        inject_at = inject ? int'($urandom_range(0, exp_cycles - 1)) : -1;

        @(negedge clk);
        set_start(which, 1'b1);
        @(posedge clk); #1;
        set_start(which, 1'b0);
        check({tag, " busy_after_start"}, 32'(busy_s), 32'd1);
        cycles  = 0;
        busy_ok = 1'b1;
        while (!done_s && cycles < full + 20) begin
            if (cycles == inject_at) set_start(which, 1'b1);
            @(posedge clk); #1;
            set_start(which, 1'b0);
            cycles++;
            if (!done_s && !busy_s) busy_ok = 1'b0;
        end
        check({tag, " done_latency"}, 32'(cycles), 32'(exp_cycles));
        check({tag, " busy_span"}, 32'(busy_ok), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy_s), 32'd0);
        check({tag, " error"}, 32'(error_s), 32'(first >= 0));
        check({tag, " err_count"}, 32'(ec_s), 32'(errs));
        check({tag, " first_fail_vec"}, 32'(ffv_s), 32'(fvec));
        check({tag, " first_fail_mask"}, 32'(ffm_s), 32'(fmask));
`ifdef PAD_SWEEP_STOP_ON_ERROR_EN
        if (first >= 0)
            check({tag, " held_vec"},
                  32'((ie_s << (2 * n)) | (oe_s << n) | tp_s), 32'(fvec));
`else
        check({tag, " idle_pads"}, 32'({ie_s, oe_s, tp_s}), 32'd0);
`endif
        ec_hold = ec_s;
        repeat (3) @(posedge clk);
        #1;
        check({tag, " done_hold"}, 32'(done_s), 32'd1);
        check({tag, " count_hold"}, 32'(ec_s), 32'(ec_hold));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        sel = 0;
        check("rst outputs_a", 32'({ie_a, oe_a, tp_a, busy_a, done_a, error_a}), 32'd0);
        check("rst results_a", 32'({ec_a, ffv_a, ffm_a}), 32'd0);
        check("rst outputs_b", 32'({ie_b, oe_b, tp_b, busy_b, done_b, error_b, ec_b}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed: clean net, stuck-0 on pad 0, clean re-sweep from DONE
        // with a start pulse during busy, stuck-1 on pad 1.
        sweep("clean", 0, 4'b0000, 4'b0000, 1'b0);
        sweep("stuck0_p0", 0, 4'b0001, 4'b0000, 1'b0);
        sweep("resweep", 0, 4'b0000, 4'b0000, 1'b1);
        sweep("stuck1_p1", 0, 4'b0000, 4'b0010, 1'b0);
        sweep("small_clean", 1, 4'b0000, 4'b0000, 1'b0);

        // Reset mid-sweep, during vector 20 SETTLE (cycle 3*20+1 after start).
        sel = 0;
        s0_a = '0; s1_a = '0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (61) @(posedge clk);
        #1;
        check("pre_rst busy", 32'(busy_a), 32'd1);
        check("pre_rst pads", 32'({ie_a, oe_a, tp_a}), 32'b010100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst outputs", 32'({ie_a, oe_a, tp_a, busy_a, done_a, error_a}), 32'd0);
        check("mid_rst results", 32'({ec_a, ffv_a, ffm_a}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst idle", 32'({busy_a, done_a}), 32'd0);
        sweep("after_rst", 0, 4'b0000, 4'b0000, 1'b0);

        // Randomized fault patterns on both instances.
        for (int k = 0; k < 6; k++) begin
            sweep("rand_a", 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : 0),
                  1'($urandom_range(0, 1)));
            sweep("rand_b", 1, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 3) == 0 ? 1 : 0),
                  1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
